// File: rtl/mem_loader.sv
// mem_loader: streams x_words activation words followed by w_words weight
// words from a valid/ready source into the core's x_bank / w_bank memory port,
// then raises a level-type load-complete flag for the core trigger input.
// Optional feature: define MEM_LOADER_CHECKSUM_EN to add checksum_o, the XOR
// of every word accepted since the last accepted start_i.
module mem_loader #(
  parameter int bw         = 4,
  parameter int row        = 8,
  parameter int addr_width = 8,
  parameter int x_words    = 144,
  parameter int w_words    = 72
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [bw*row-1:0]     s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [addr_width-1:0] mem_addr_o,
  output logic                  mem_bank_sel_o,
  output logic                  mem_wen_n_o,
  output logic                  mem_cen_n_o,
  output logic [bw*row-1:0]     mem_data_o,
  output logic                  mem_load_complete_o,
  output logic                  busy_o
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [bw*row-1:0]     checksum_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_X = 2'd1,
    LOAD_W = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last word index of each bank; the counter wraps to 0 on these.
  localparam logic [addr_width-1:0] X_LAST = addr_width'(x_words - 1);
  localparam logic [addr_width-1:0] W_LAST = addr_width'(w_words - 1);

  state_t                  state_q;
  logic [addr_width-1:0]   cnt_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    complete_q;
  logic                    cen_n_q;
  logic                    wen_n_q;
  logic                    bank_q;
  logic [addr_width-1:0]   addr_q;
  logic [bw*row-1:0]       data_q;
  logic                    handshake;

  // ready_q is only ever high in LOAD_X/LOAD_W, so this is the accept strobe.
  assign handshake = s_valid_i & ready_q;

  // Load sequencer: state, word counter and the registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      // Complete follows DONE one cycle late, so it rises the cycle after
      // the final write strobe and drops as soon as a restart is accepted.
      complete_q <= (state_q == DONE) && !start_i;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= LOAD_X;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD_X: begin
          if (handshake) begin
            if (cnt_q == X_LAST) begin
              state_q <= LOAD_W;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + addr_width'(1);
            end
          end
        end
        LOAD_W: begin
          if (handshake) begin
            if (cnt_q == W_LAST) begin
              state_q <= DONE;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + addr_width'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory write port: one registered write per accepted word, idle otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cen_n_q <= 1'b1;
      wen_n_q <= 1'b1;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (handshake) begin
      cen_n_q <= 1'b0;
      wen_n_q <= 1'b0;
      bank_q  <= (state_q == LOAD_W);
      addr_q  <= cnt_q;
      data_q  <= s_data_i;
    end else begin
      // Bank select deliberately holds its last value between writes.
      cen_n_q <= 1'b1;
      wen_n_q <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [bw*row-1:0] csum_q;

  // Running XOR of accepted words, restarted whenever a load is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_q <= '0;
    end else if (start_i && (state_q == IDLE || state_q == DONE)) begin
      csum_q <= '0;
    end else if (handshake) begin
      csum_q <= csum_q ^ s_data_i;
    end
  end

  assign checksum_o = csum_q;
`endif

  assign s_ready_o           = ready_q;
  assign busy_o              = busy_q;
  assign mem_load_complete_o = complete_q;
  assign mem_cen_n_o         = cen_n_q;
  assign mem_wen_n_o         = wen_n_q;
  assign mem_bank_sel_o      = bank_q;
  assign mem_addr_o          = addr_q;
  assign mem_data_o          = data_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench for mem_loader. The stimulus side pushes the
// expected memory write for every word it hands over; a negedge monitor pops
// and compares whenever the DUT strobes a write, and checks the idle port
// values on every other cycle. Set MEM_LOADER_CHECKSUM_EN to also check checksum_o.
module tb_mem_loader;
  localparam int BW = 4;
  localparam int ROW = 8;
  localparam int AW = 8;
  localparam int XW = 144;
  localparam int WW = 72;
  localparam int DW = BW * ROW;
  localparam int NW = XW + WW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_bank_sel_o;
  logic          mem_wen_n_o;
  logic          mem_cen_n_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_load_complete_o;
  logic          busy_o;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum_o;
`endif

  mem_loader #(.bw(BW), .row(ROW), .addr_width(AW), .x_words(XW), .w_words(WW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_i             (start_i),
    .s_data_i            (s_data_i),
    .s_valid_i           (s_valid_i),
    .s_ready_o           (s_ready_o),
    .mem_addr_o          (mem_addr_o),
    .mem_bank_sel_o      (mem_bank_sel_o),
    .mem_wen_n_o         (mem_wen_n_o),
    .mem_cen_n_o         (mem_cen_n_o),
    .mem_data_o          (mem_data_o),
    .mem_load_complete_o (mem_load_complete_o),
    .busy_o              (busy_o)
`ifdef MEM_LOADER_CHECKSUM_EN
    ,
    .checksum_o          (checksum_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   strobes = 0;
  int   rises = 0;
  logic last_bank = 1'b0;
  logic prev_cpl = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return DW'(kk * 32'h0101_0101);
  endfunction

  // Monitor: pop and compare on each write strobe, check idle values otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) last_bank = 1'b0;
    if (mem_cen_n_o === 1'b0) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_strobe: bank %0d addr %0d data %h, none expected",
                 mem_bank_sel_o, mem_addr_o, mem_data_o);
      end else begin
        e = exp_q.pop_front();
        $display("wr bank=%0d addr=%0d data=%h", mem_bank_sel_o, mem_addr_o, mem_data_o);
        chk("write", 64'({mem_wen_n_o, mem_bank_sel_o, mem_addr_o, mem_data_o}),
            64'({1'b0, e.bank, e.addr, e.data}));
        last_bank = e.bank;
      end
    end else begin
      chk("idle_port", 64'({mem_wen_n_o, mem_bank_sel_o, mem_addr_o, mem_data_o}),
          64'({1'b1, last_bank, AW'(0), DW'(0)}));
    end
    if (mem_load_complete_o === 1'b1 && prev_cpl !== 1'b1) rises++;
    prev_cpl = mem_load_complete_o;
  end

  task automatic pulse_start(input bit was_done);
    @(posedge clk); #1;
    if (was_done) chk("complete_in_done", 64'(mem_load_complete_o), 64'(1));
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("ready_after_start", 64'(s_ready_o), 64'(1));
    chk("busy_after_start", 64'(busy_o), 64'(1));
    if (was_done) chk("complete_clears", 64'(mem_load_complete_o), 64'(0));
  endtask

  // Stream words 0..NW-1; optional 1/0 valid toggling, a start pulse on word
  // start_at, and an abort (return) before word abort_after.
  task automatic load(input bit toggle, input int start_at, input int abort_after);
    int            s0;
    int            r0;
    int            tries;
    exp_t          e;
    logic [DW-1:0] cs;
    s0 = strobes;
    r0 = rises;
    cs = '0;
    for (int k = 0; k < NW; k++) begin
      if (k == abort_after) begin
        s_valid_i = 1'b0;
        s_data_i  = '0;
        return;
      end
      if (toggle && k > 0) begin
        s_valid_i = 1'b0;
        s_data_i  = '0;
        @(posedge clk); #1;
      end
      s_data_i  = word(k);
      s_valid_i = 1'b1;
      start_i   = (k == start_at);
      tries = 0;
      while (s_ready_o !== 1'b1 && tries < 16) begin
        @(posedge clk); #1;
        tries++;
      end
      if (tries == 16) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: word %0d never accepted", k);
        s_valid_i = 1'b0;
        start_i   = 1'b0;
        return;
      end
      e.bank = (k >= XW);
      e.addr = AW'((k >= XW) ? k - XW : k);
      e.data = word(k);
      exp_q.push_back(e);
      cs ^= word(k);
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    s_valid_i = 1'b0;
    s_data_i  = '0;
    chk("complete_t1", 64'(mem_load_complete_o), 64'(0));
    chk("ready_after_last", 64'(s_ready_o), 64'(0));
    chk("busy_after_last", 64'(busy_o), 64'(0));
    @(posedge clk); #1;
    chk("complete_t2", 64'(mem_load_complete_o), 64'(1));
    @(negedge clk); #1;
    chk("strobe_count", 64'(strobes - s0), 64'(NW));
    chk("complete_rises", 64'(rises - r0), 64'(1));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("checksum", 64'(checksum_o), 64'(cs));
`endif
  endtask

  initial begin
    int s_before;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(s_ready_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_complete", 64'(mem_load_complete_o), 64'(0));
    chk("rst_port", 64'({mem_cen_n_o, mem_wen_n_o, mem_bank_sel_o, mem_addr_o, mem_data_o}),
        64'({1'b1, 1'b1, 1'b0, AW'(0), DW'(0)}));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start_ready", 64'(s_ready_o), 64'(0));

    // Continuous-valid load.
    pulse_start(1'b0);
    load(1'b0, -1, -1);
    // Restart from DONE with valid toggling every cycle.
    pulse_start(1'b1);
    load(1'b1, -1, -1);
    // start_i during LOAD_W at cnt=10 must be ignored.
    pulse_start(1'b1);
    load(1'b0, XW + 10, -1);
    // Abort after 50 x words with an asynchronous reset mid-cycle.
    s_before = strobes;
    pulse_start(1'b1);
    load(1'b0, -1, 50);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_port", 64'({mem_cen_n_o, mem_wen_n_o, mem_bank_sel_o, mem_addr_o, mem_data_o}),
        64'({1'b1, 1'b1, 1'b0, AW'(0), DW'(0)}));
    chk("abort_ready", 64'(s_ready_o), 64'(0));
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_complete", 64'(mem_load_complete_o), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("abort_strobes", 64'(strobes - s_before), 64'(50));
    chk("abort_scoreboard", 64'(exp_q.size()), 64'(0));
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("after_abort_ready", 64'(s_ready_o), 64'(0));
    pulse_start(1'b0);
    load(1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
